// File: rtl/pwm_multich_pkg.sv
// Shared encodings for the multi-channel dead-time PWM: carrier modes, event selects and
// the per-channel dead-time FSM states.
package pwm_multich_pkg;

    typedef enum logic [1:0] {
        ModeHold   = 2'b00,
        ModeUp     = 2'b01,
        ModeDown   = 2'b10,
        ModeUpDown = 2'b11
    } count_mode_e;

    typedef enum logic [1:0] {
        SyncNone = 2'b00,
        SyncMin  = 2'b01,
        SyncMax  = 2'b10,
        SyncBoth = 2'b11
    } sync_mode_e;

    typedef enum logic [1:0] {
        StDead = 2'b00,
        StAOn  = 2'b01,
        StBOn  = 2'b10
    } dt_state_e;

    localparam int unsigned PrescW = 4;

    // At the turn of an up-down carrier only one extreme is ever true per update, so a plain OR
    // of the selected conditions gives exactly one event per extreme.
    function automatic logic sync_event(input logic [1:0] mode, input logic at_min,
                                        input logic at_max);
        return (mode[0] & at_min) | (mode[1] & at_max);
    endfunction

endpackage

// File: rtl/pwm_deadtime_ch.sv
// One PWM channel: turns a registered raw PWM level into complementary high/low-side drives
// with a dead interval of dead_time+1 enabled cycles around every transition.
module pwm_deadtime_ch
    import pwm_multich_pkg::*;
#(
    parameter int unsigned DTW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           raw,
    input  logic           raw_rst,
    input  logic [DTW-1:0] dead_time,
    output logic           pwm_a,
    output logic           pwm_b
);

    dt_state_e      state_q;
    logic [DTW-1:0] cnt_q;
    logic           tgt_q;
    logic           pwm_a_q;
    logic           pwm_b_q;

    // tgt_q is the raw level the dead interval is waiting to settle on; any new level restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StDead;
            cnt_q   <= dead_time;
            tgt_q   <= raw_rst;
            pwm_a_q <= 1'b0;
            pwm_b_q <= 1'b0;
        end else if (ce) begin
            case (state_q)
                StAOn: begin
                    if (!raw) begin
                        state_q <= StDead;
                        cnt_q   <= dead_time;
                        tgt_q   <= 1'b0;
                        pwm_a_q <= 1'b0;
                    end
                end
                StBOn: begin
                    if (raw) begin
                        state_q <= StDead;
                        cnt_q   <= dead_time;
                        tgt_q   <= 1'b1;
                        pwm_b_q <= 1'b0;
                    end
                end
                StDead: begin
                    if (raw != tgt_q) begin
                        tgt_q <= raw;
                        cnt_q <= dead_time;
                    end else if (cnt_q == '0) begin
                        state_q <= raw ? StAOn : StBOn;
                        pwm_a_q <= raw;
                        pwm_b_q <= ~raw;
                    end else begin
                        cnt_q <= cnt_q - DTW'(1);
                    end
                end
                default: begin
                    state_q <= StDead;
                    cnt_q   <= dead_time;
                    pwm_a_q <= 1'b0;
                    pwm_b_q <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_a = pwm_a_q;
    assign pwm_b = pwm_b_q;

endmodule

// File: rtl/pwm_multich_dt.sv
// Multi-channel PWM: shared carrier timer, event prescaler driving sync, shadow-loaded compare
// registers and one dead-time channel per output pair.
module pwm_multich_dt
    import pwm_multich_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 4,
    parameter int unsigned DTW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [WIDTH-1:0]     count_max,
    input  logic [WIDTH-1:0]     init_carr,
    input  logic [1:0]           count_mode,
    input  logic [1:0]           sync_mode,
    input  logic [PrescW-1:0]    event_count,
    input  logic [NCH*WIDTH-1:0] compare,
    input  logic [NCH-1:0]       sig_pwm,
    input  logic [DTW-1:0]       dead_time,
    output logic [WIDTH-1:0]     carrier,
    output logic                 sync,
    output logic [NCH-1:0]       pwm_a,
    output logic [NCH-1:0]       pwm_b
);

    logic [WIDTH-1:0]           carr_q, carr_d;
    logic                       up_q, up_d;
    logic [PrescW-1:0]          presc_q, presc_d;
    logic                       sync_q, sync_d;
    logic                       evt;
    logic                       load;
    logic [NCH-1:0][WIDTH-1:0]  act_q, act_d;
    logic [NCH-1:0]             raw_q, raw_d;

    // Carrier next value; a count_max below the carrier is handled by the >= / > tests.
    always_comb begin
        carr_d = carr_q;
        up_d   = up_q;
        case (count_mode_e'(count_mode))
            ModeHold: carr_d = carr_q;
            ModeUp:   carr_d = (carr_q >= count_max) ? '0 : carr_q + WIDTH'(1);
            ModeDown: begin
                carr_d = (carr_q == '0 || carr_q > count_max) ? count_max : carr_q - WIDTH'(1);
            end
            ModeUpDown: begin
                if (up_q) begin
                    if (carr_q >= count_max) begin
                        up_d   = 1'b0;
                        carr_d = (carr_q == '0) ? '0 : carr_q - WIDTH'(1);
                    end else begin
                        carr_d = carr_q + WIDTH'(1);
                    end
                end else begin
                    if (carr_q == '0) begin
                        up_d   = 1'b1;
                        carr_d = (count_max == '0) ? '0 : WIDTH'(1);
                    end else begin
                        carr_d = carr_q - WIDTH'(1);
                    end
                end
            end
            default: carr_d = carr_q;
        endcase
    end

    // Events are taken on the updated carrier so sync lines up with the value that caused it.
    assign evt = sync_event(sync_mode, carr_d == '0, carr_d == count_max);

    always_comb begin
        presc_d = presc_q;
        sync_d  = 1'b0;
        if (sync_mode_e'(sync_mode) == SyncNone) begin
            presc_d = '0;
        end else if (evt) begin
            if (presc_q == event_count) begin
                presc_d = '0;
                sync_d  = 1'b1;
            end else begin
                presc_d = presc_q + PrescW'(1);
            end
        end
    end

    assign load = (sync_mode_e'(sync_mode) == SyncNone) || sync_q;

    // Raw is computed against the next carrier so raw_q stays aligned with carrier.
    always_comb begin
        act_d = act_q;
        raw_d = raw_q;
        for (int i = 0; i < int'(NCH); i++) begin
            act_d[i] = load ? compare[i*WIDTH +: WIDTH] : act_q[i];
            raw_d[i] = (carr_d < act_d[i]) ^ sig_pwm[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carr_q  <= init_carr;
            up_q    <= 1'b1;
            presc_q <= '0;
            sync_q  <= 1'b0;
            act_q   <= '0;
            raw_q   <= sig_pwm;
        end else if (ce) begin
            carr_q  <= carr_d;
            up_q    <= up_d;
            presc_q <= presc_d;
            sync_q  <= sync_d;
            act_q   <= act_d;
            raw_q   <= raw_d;
        end
    end

    assign carrier = carr_q;
    assign sync    = sync_q;

    for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
        pwm_deadtime_ch #(
            .DTW(DTW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .ce        (ce),
            .raw       (raw_q[g]),
            .raw_rst   (sig_pwm[g]),
            .dead_time (dead_time),
            .pwm_a     (pwm_a[g]),
            .pwm_b     (pwm_b[g])
        );
    end

endmodule
